// File: rtl/freq_meter_pkg.sv
// Shared types and helpers for the frequency/period meter.
// Provides the FSM state encoding and the counter saturation value.
package freq_meter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_MEAS = 2'd2
    } state_t;

    localparam int CNT_W_DEF = 16;

    // Largest value an unsigned counter of width w can hold.
    function automatic logic [31:0] cnt_max(input int w);
        return (32'd1 << w) - 32'd1;
    endfunction

endpackage

// File: rtl/edge_sync.sv
// Synchronizes the divider output into the clk domain and derives
// single-cycle rise/fall strobes from the synchronized level.
module edge_sync
    import freq_meter_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic q_in,
    output logic q_s,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   q_d_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
            q_d_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], q_in};
            q_d_q  <= sync_q[SYNC_STAGES-1];
        end
    end

    assign q_s  = sync_q[SYNC_STAGES-1];
    assign rise = q_s & ~q_d_q;
    assign fall = ~q_s & q_d_q;

endmodule

// File: rtl/freq_period_meter.sv
// Measures the period (and, with DUTY_MEAS_EN defined, the high time) of the
// divider output in system-clock cycles, flagging a sticky timeout on stall.
module freq_period_meter
    import freq_meter_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             q_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             timeout,
    output logic [1:0]       dbg_state
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max(CNT_W));
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    logic q_s, rise, fall;

    edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk  (clk),
        .rst  (rst),
        .q_in (q_in),
        .q_s  (q_s),
        .rise (rise),
        .fall (fall)
    );

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q, cnt_d, period_q;
    logic             meas_valid_q, timeout_q;

    assign cnt_d = cnt_q + ONE;

`ifdef DUTY_MEAS_EN
    logic [CNT_W-1:0] hcnt_q, hi_lat_q, high_time_q;

    // High-time counter restarts on each rise; its value is latched at the fall.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hcnt_q   <= '0;
            hi_lat_q <= '0;
        end else begin
            if (!en)
                hcnt_q <= '0;
            else if (rise)
                hcnt_q <= ONE;
            else if (q_s && hcnt_q != CNT_MAX)
                hcnt_q <= hcnt_q + ONE;
            if (fall)
                hi_lat_q <= hcnt_q;
        end
    end

    assign high_time = high_time_q;
`else
    logic unused_sync;
    assign unused_sync = q_s ^ fall;
    assign high_time   = '0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            period_q     <= '0;
            meas_valid_q <= 1'b0;
            timeout_q    <= 1'b0;
`ifdef DUTY_MEAS_EN
            high_time_q  <= '0;
`endif
        end else begin
            meas_valid_q <= 1'b0;
            if (!en) begin
                state_q   <= ST_IDLE;
                cnt_q     <= '0;
                timeout_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: state_q <= ST_ARM;
                    ST_ARM: begin
                        if (rise) begin
                            state_q <= ST_MEAS;
                            cnt_q   <= ONE;
                        end
                    end
                    ST_MEAS: begin
                        if (rise) begin
                            period_q     <= cnt_q;
                            meas_valid_q <= 1'b1;
                            timeout_q    <= 1'b0;
                            cnt_q        <= ONE;
`ifdef DUTY_MEAS_EN
                            high_time_q  <= hi_lat_q;
`endif
                        end else if (cnt_d == CNT_MAX) begin
                            // Stop one short of saturation so the counter never wraps.
                            timeout_q <= 1'b1;
                            state_q   <= ST_ARM;
                            cnt_q     <= '0;
                        end else begin
                            cnt_q <= cnt_d;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign period     = period_q;
    assign meas_valid = meas_valid_q;
    assign timeout    = timeout_q;
    assign dbg_state  = state_q;

endmodule
